// File: rtl/rvc_packer.sv
// Compressing packer: re-encodes eligible RV32I instructions to RVC
// and packs 16/32-bit parcels little-endian into 32-bit words.
module rvc_packer #(
    parameter int EN_COMPRESS = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             flush_done,
    output logic             half_pending,
    output logic [CNT_W-1:0] n_comp
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [15:0]      hold;
    logic [15:0]      hold_n;
    logic [31:0]      word_n;
    logic             valid_n;
    logic             done_n;
    logic [CNT_W-1:0] cnt_n;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic        is_add;
    logic        is_addi;
    logic        imm_ok;
    logic        is_c;
    logic [15:0] cpar;
    logic        accept;
    logic        flush_go;

    assign opc = in_instr[6:0];
    assign rd  = in_instr[11:7];
    assign f3  = in_instr[14:12];
    assign rs1 = in_instr[19:15];
    assign rs2 = in_instr[24:20];
    assign f7  = in_instr[31:25];
    assign imm = in_instr[31:20];

    assign is_add  = (opc == 7'b0110011) && (f3 == 3'b000)
                   && (f7 == 7'b0000000);
    assign is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
    // Fits in 6 signed bits when the upper seven bits all match bit 5.
    assign imm_ok  = (imm[11:5] == 7'h00) || (imm[11:5] == 7'h7f);

    assign in_ready     = !out_valid || out_ready;
    assign accept       = in_valid && in_ready;
    assign flush_go     = flush && in_ready && !in_valid;
    assign half_pending = (state == HALF);

    // Compression decoder; the four forms are mutually exclusive.
    always_comb begin
        is_c = 1'b0;
        cpar = 16'h0000;
        if (EN_COMPRESS != 0) begin
            unique case (1'b1)
                (is_add && rs1 == 5'd0 && rd != 5'd0
                 && rs2 != 5'd0): begin
                    is_c = 1'b1;
                    cpar = {4'b1000, rd, rs2, 2'b10};
                end
                (is_add && rs1 == rd && rd != 5'd0
                 && rs2 != 5'd0): begin
                    is_c = 1'b1;
                    cpar = {4'b1001, rd, rs2, 2'b10};
                end
                (is_addi && rs1 == 5'd0 && rd != 5'd0
                 && imm_ok): begin
                    is_c = 1'b1;
                    cpar = {3'b010, imm[5], rd, imm[4:0], 2'b01};
                end
                (is_addi && rs1 == rd && rd != 5'd0
                 && imm != 12'd0 && imm_ok): begin
                    is_c = 1'b1;
                    cpar = {3'b000, imm[5], rd, imm[4:0], 2'b01};
                end
                default: begin
                    is_c = 1'b0;
                    cpar = 16'h0000;
                end
            endcase
        end
    end

    // Next-state, packing and flush logic.
    always_comb begin
        state_n = state;
        hold_n  = hold;
        word_n  = out_word;
        valid_n = out_valid && !out_ready;
        done_n  = 1'b0;
        cnt_n   = n_comp;
        if (accept) begin
            if (is_c && n_comp != {CNT_W{1'b1}}) begin
                cnt_n = n_comp + 1'b1;
            end
            if (state == EMPTY) begin
                if (is_c) begin
                    hold_n  = cpar;
                    state_n = HALF;
                end else begin
                    word_n  = in_instr;
                    valid_n = 1'b1;
                end
            end else begin
                valid_n = 1'b1;
                if (is_c) begin
                    word_n  = {cpar, hold};
                    state_n = EMPTY;
                end else begin
                    word_n = {in_instr[15:0], hold};
                    hold_n = in_instr[31:16];
                end
            end
        end else if (flush_go) begin
            done_n = 1'b1;
            if (state == HALF) begin
                word_n  = {16'h0001, hold};
                valid_n = 1'b1;
                state_n = EMPTY;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            hold       <= 16'h0000;
            out_word   <= 32'h0;
            out_valid  <= 1'b0;
            flush_done <= 1'b0;
            n_comp     <= '0;
        end else begin
            state      <= state_n;
            hold       <= hold_n;
            out_word   <= word_n;
            out_valid  <= valid_n;
            flush_done <= done_n;
            n_comp     <= cnt_n;
        end
    end

endmodule

// File: tb/tb_rvc_packer.sv
// Directed bench for rvc_packer: compressing, uncompressed and
// narrow-counter instances share one stimulus stream.
module tb_rvc_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid, flush_done, half_pending;
    logic [31:0] out_word;
    logic [15:0] n_comp;

    logic        in_ready0, out_valid0, flush_done0, half_pending0;
    logic [31:0] out_word0;
    logic [15:0] n_comp0;

    logic        in_ready2, out_valid2, flush_done2, half_pending2;
    logic [31:0] out_word2;
    logic [1:0]  n_comp2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rvc_packer #(.EN_COMPRESS(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(in_ready), .in_instr(in_instr), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .flush_done(flush_done),
        .half_pending(half_pending), .n_comp(n_comp)
    );

    rvc_packer #(.EN_COMPRESS(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(in_ready0), .in_instr(in_instr), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_word(out_word0), .flush_done(flush_done0),
        .half_pending(half_pending0), .n_comp(n_comp0)
    );

    rvc_packer #(.EN_COMPRESS(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(in_ready2), .in_instr(in_instr), .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_word(out_word2), .flush_done(flush_done2),
        .half_pending(half_pending2), .n_comp(n_comp2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    logic [31:0] held;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_vld", {31'd0, out_valid}, 32'd0);
        chk("rst_word", out_word, 32'h0);
        chk("rst_half", {31'd0, half_pending}, 32'd0);
        chk("rst_cnt", {16'd0, n_comp}, 32'd0);
        chk("rst_fd", {31'd0, flush_done}, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: c.add then flush pads with c.nop
        send(32'h006282B3);
        chk("t1_half", {31'd0, half_pending}, 32'd1);
        chk("t1_novld", {31'd0, out_valid}, 32'd0);
        do_flush();
        chk("t1_vld", {31'd0, out_valid}, 32'd1);
        chk("t1_word", out_word, 32'h0001929A);
        chk("t1_fd", {31'd0, flush_done}, 32'd1);
        chk("t1_cnt", {16'd0, n_comp}, 32'd1);
        chk("t1_half0", {31'd0, half_pending}, 32'd0);

        // 2: two compressed parcels make one word
        send(32'h006282B3);
        chk("t2_half1", {31'd0, half_pending}, 32'd1);
        chk("t2_novld", {31'd0, out_valid}, 32'd0);
        chk("t2_fd0", {31'd0, flush_done}, 32'd0);
        send(32'h006282B3);
        chk("t2_half0", {31'd0, half_pending}, 32'd0);
        chk("t2_vld", {31'd0, out_valid}, 32'd1);
        chk("t2_word", out_word, 32'h929A929A);

        // 3: c.addi, straddling lw, flush
        send(32'h00150513);
        chk("t3_novld", {31'd0, out_valid}, 32'd0);
        chk("t3_half", {31'd0, half_pending}, 32'd1);
        send(32'h00012083);
        chk("t3_vld", {31'd0, out_valid}, 32'd1);
        chk("t3_word1", out_word, 32'h20830505);
        chk("t3_half2", {31'd0, half_pending}, 32'd1);
        do_flush();
        chk("t3_word2", out_word, 32'h00010001);
        chk("t3_fd", {31'd0, flush_done}, 32'd1);
        chk("t3_cnt", {16'd0, n_comp}, 32'd4);
        chk("t3_sat", {30'd0, n_comp2}, 32'd3);
        step();
        chk("t3_drain", {31'd0, out_valid}, 32'd0);

        // 4: backpressure holds the word steady
        out_ready = 1'b0;
        send(32'h00012083);
        chk("t4_vld", {31'd0, out_valid}, 32'd1);
        chk("t4_rdy", {31'd0, in_ready}, 32'd0);
        held = out_word;
        chk("t4_word", held, 32'h00012083);
        in_valid = 1'b1;
        in_instr = 32'h02008093;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_hold", out_word, 32'h00012083);
        end
        chk("t4_stall", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        #1;
        chk("t4_rdy1", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("t4_next", out_word, 32'h02008093);
        chk("t4_vld2", {31'd0, out_valid}, 32'd1);
        chk("t4_cnt", {16'd0, n_comp}, 32'd4);
        step();
        chk("t4_once", {31'd0, out_valid}, 32'd0);

        // 5: reset discards pending halfword
        send(32'h00150513);
        chk("t5_half", {31'd0, half_pending}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_vld", {31'd0, out_valid}, 32'd0);
        chk("t5_half0", {31'd0, half_pending}, 32'd0);
        chk("t5_cnt", {16'd0, n_comp}, 32'd0);
        do_flush();
        chk("t5_fl_vld", {31'd0, out_valid}, 32'd0);
        chk("t5_fl_fd", {31'd0, flush_done}, 32'd1);
        flush = 1'b1;
        step();
        chk("t5_fd_hold", {31'd0, flush_done}, 32'd1);
        flush = 1'b0;
        step();
        chk("t5_fd_low", {31'd0, flush_done}, 32'd0);

        // 6: pass-through instance and out-of-range addi
        send(32'h006282B3);
        chk("t6_w0", out_word0, 32'h006282B3);
        chk("t6_v0", {31'd0, out_valid0}, 32'd1);
        chk("t6_c0", {16'd0, n_comp0}, 32'd0);
        chk("t6_h1", {31'd0, half_pending}, 32'd1);
        send(32'h02008093);
        chk("t6_w0b", out_word0, 32'h02008093);
        chk("t6_wc", out_word, 32'h8093929A);
        chk("t6_cnt", {16'd0, n_comp}, 32'd1);
        do_flush();
        chk("t6_fw", out_word, 32'h00010200);
        chk("t6_fv0", {31'd0, out_valid0}, 32'd0);
        chk("t6_fd0", {31'd0, flush_done0}, 32'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
